m_gate_pipe: RTL and testbench

Parametrised, pipelined N-input logic gate: reduces `NIN` operand words of `WIDTH` bits with a runtime-selected bitwise operation (OR, AND, XOR and inverses) and delivers the result through a 2-entry output buffer with valid/ready handshakes. It generalises the team's single-bit two-input OR gate into a reusable datapath primitive. It sits between operand producers and any consumer that can apply backpressure.

---
 rtl/gate_pkg.sv | 15 +
 rtl/m_gate_reduce.sv | 40 ++++
 rtl/m_gate_pipe.sv | 100 ++++++++++
 tb/tb_m_gate_pipe.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/gate_pkg.sv
// Shared constants for the gate pipeline: operation codes and result-counter width.
package gate_pkg;

  localparam logic [2:0] OP_OR   = 3'd0;
  localparam logic [2:0] OP_AND  = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_NAND = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_PASS = 3'd6;
  localparam logic [2:0] OP_ZERO = 3'd7;

  localparam int CNT_W = 16;

endpackage

// File: rtl/m_gate_reduce.sv
// Combinational N-input bitwise reduction selected by a 3-bit op code.
module m_gate_reduce import gate_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int NIN   = 4
) (
  input  logic [2:0]           op,
  input  logic [NIN*WIDTH-1:0] data,
  output logic [WIDTH-1:0]     result
);

  logic [WIDTH-1:0] or_acc;
  logic [WIDTH-1:0] and_acc;
  logic [WIDTH-1:0] xor_acc;

  always_comb begin
    or_acc  = '0;
    and_acc = '1;
    xor_acc = '0;
    for (int k = 0; k < NIN; k++) begin
      or_acc  = or_acc  | data[k*WIDTH +: WIDTH];
      and_acc = and_acc & data[k*WIDTH +: WIDTH];
      xor_acc = xor_acc ^ data[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    result = '0;
    case (op)
      OP_OR:   result = or_acc;
      OP_AND:  result = and_acc;
      OP_XOR:  result = xor_acc;
      OP_NOR:  result = ~or_acc;
      OP_NAND: result = ~and_acc;
      OP_XNOR: result = ~xor_acc;
      OP_PASS: result = data[WIDTH-1:0];
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/m_gate_pipe.sv
// Pipelined N-input gate with a 2-entry valid/ready output buffer.
// Optional GATE_PIPE_PARITY_EN adds a stored per-entry parity output.
module m_gate_pipe import gate_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int NIN   = 4
) (
  input  logic                 w_clk,
  input  logic                 w_rst,
  input  logic                 w_in_valid,
  output logic                 w_in_ready,
  input  logic [2:0]           w_in_op,
  input  logic [NIN*WIDTH-1:0] w_in_data,
  output logic                 w_out_valid,
  input  logic                 w_out_ready,
  output logic [WIDTH-1:0]     w_out_data,
  output logic                 w_out_any,
`ifdef GATE_PIPE_PARITY_EN
  output logic                 w_out_parity,
`endif
  output logic [CNT_W-1:0]     w_out_count
);

  logic [WIDTH-1:0] r_buf [2];
  logic             r_rd_ptr;
  logic             r_wr_ptr;
  logic [1:0]       r_cnt;
  logic [1:0]       cnt_next;
  logic             r_in_ready;
  logic [CNT_W-1:0] r_count;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] reduce_result;

  m_gate_reduce #(
    .WIDTH (WIDTH),
    .NIN   (NIN)
  ) u_reduce (
    .op     (w_in_op),
    .data   (w_in_data),
    .result (reduce_result)
  );

  assign push = w_in_valid & r_in_ready;
  assign pop  = (r_cnt != 2'd0) & w_out_ready;

  always_comb begin
    cnt_next = r_cnt;
    case ({push, pop})
      2'b10:   cnt_next = r_cnt + 2'd1;
      2'b01:   cnt_next = r_cnt - 2'd1;
      default: cnt_next = r_cnt;
    endcase
  end

  // Ready is registered from the next occupancy so it never depends on w_out_ready combinationally.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_buf[0]   <= '0;
      r_buf[1]   <= '0;
      r_rd_ptr   <= 1'b0;
      r_wr_ptr   <= 1'b0;
      r_cnt      <= 2'd0;
      r_in_ready <= 1'b1;
      r_count    <= '0;
    end else begin
      if (push) begin
        r_buf[r_wr_ptr] <= reduce_result;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (pop) begin
        r_rd_ptr <= ~r_rd_ptr;
        r_count  <= r_count + CNT_W'(1);
      end
      r_cnt      <= cnt_next;
      r_in_ready <= (cnt_next != 2'd2);
    end
  end

`ifdef GATE_PIPE_PARITY_EN
  logic r_par [2];

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_par[0] <= 1'b0;
      r_par[1] <= 1'b0;
    end else if (push) begin
      r_par[r_wr_ptr] <= ^reduce_result;
    end
  end

  assign w_out_parity = r_par[r_rd_ptr];
`endif

  assign w_in_ready  = r_in_ready;
  assign w_out_valid = (r_cnt != 2'd0);
  assign w_out_data  = r_buf[r_rd_ptr];
  assign w_out_any   = |w_out_data;
  assign w_out_count = r_count;

endmodule

// File: tb/tb_m_gate_pipe.sv
// Self-checking bench for m_gate_pipe: directed plan steps plus random traffic vs a queue model.
module tb_m_gate_pipe;

  localparam int WIDTH = 8;
  localparam int NIN   = 4;

  logic                 w_clk;
  logic                 w_rst;
  logic                 w_in_valid;
  logic                 w_in_ready;
  logic [2:0]           w_in_op;
  logic [NIN*WIDTH-1:0] w_in_data;
  logic                 w_out_valid;
  logic                 w_out_ready;
  logic [WIDTH-1:0]     w_out_data;
  logic                 w_out_any;
  logic [15:0]          w_out_count;
`ifdef GATE_PIPE_PARITY_EN
  logic                 w_out_parity;
`endif

  int tests = 0;
  int fails = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic [15:0]      exp_count = 16'h0000;

  m_gate_pipe #(.WIDTH(WIDTH), .NIN(NIN)) dut (
    .w_clk       (w_clk),
    .w_rst       (w_rst),
    .w_in_valid  (w_in_valid),
    .w_in_ready  (w_in_ready),
    .w_in_op     (w_in_op),
    .w_in_data   (w_in_data),
    .w_out_valid (w_out_valid),
    .w_out_ready (w_out_ready),
    .w_out_data  (w_out_data),
    .w_out_any   (w_out_any),
`ifdef GATE_PIPE_PARITY_EN
    .w_out_parity(w_out_parity),
`endif
    .w_out_count (w_out_count)
  );

  initial begin
    w_clk = 1'b0;
    forever #5 w_clk = ~w_clk;
  end

  // Reference result built operand by operand from the op-code meanings.
  function automatic logic [WIDTH-1:0] refGate(input logic [2:0] op, input logic [NIN*WIDTH-1:0] d);
    logic [WIDTH-1:0] opnd [NIN];
    logic [WIDTH-1:0] acc;
    for (int k = 0; k < NIN; k++) opnd[k] = d[k*WIDTH +: WIDTH];
    acc = '0;
    for (int b = 0; b < WIDTH; b++) begin
      int ones = 0;
      for (int k = 0; k < NIN; k++) ones += int'(opnd[k][b]);
      case (op)
        3'd0: acc[b] = (ones > 0);
        3'd1: acc[b] = (ones == NIN);
        3'd2: acc[b] = (ones % 2 == 1);
        3'd3: acc[b] = (ones == 0);
        3'd4: acc[b] = (ones != NIN);
        3'd5: acc[b] = (ones % 2 == 0);
        3'd6: acc[b] = opnd[0][b];
        default: acc[b] = 1'b0;
      endcase
    end
    return acc;
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    checkVal("in_ready", 32'(w_in_ready), 32'(exp_q.size() != 2));
    checkVal("out_valid", 32'(w_out_valid), 32'(exp_q.size() != 0));
    checkVal("out_count", 32'(w_out_count), 32'(exp_count));
    if (exp_q.size() != 0) begin
      checkVal("out_data", 32'(w_out_data), 32'(exp_q[0]));
      checkVal("out_any", 32'(w_out_any), 32'(exp_q[0] != 0));
`ifdef GATE_PIPE_PARITY_EN
      checkVal("out_parity", 32'(w_out_parity), 32'(^exp_q[0]));
`endif
    end
  endtask

  // Drive one cycle, advance the model using its own occupancy, then check after the edge.
  task automatic applyStimulus(input logic v, input logic [2:0] op,
                               input logic [NIN*WIDTH-1:0] d, input logic rdy);
    bit do_push;
    bit do_pop;
    w_in_valid  = v;
    w_in_op     = op;
    w_in_data   = d;
    w_out_ready = rdy;
    do_push = v && (exp_q.size() < 2);
    do_pop  = rdy && (exp_q.size() > 0);
    @(posedge w_clk);
    #1;
    if (do_pop) begin
      void'(exp_q.pop_front());
      exp_count = exp_count + 16'd1;
    end
    if (do_push) exp_q.push_back(refGate(op, d));
    checkOutput();
  endtask

  task automatic checkResetValues(input string tag);
    checkVal({tag, "_in_ready"}, 32'(w_in_ready), 32'd1);
    checkVal({tag, "_out_valid"}, 32'(w_out_valid), 32'd0);
    checkVal({tag, "_out_data"}, 32'(w_out_data), 32'd0);
    checkVal({tag, "_out_any"}, 32'(w_out_any), 32'd0);
    checkVal({tag, "_out_count"}, 32'(w_out_count), 32'd0);
`ifdef GATE_PIPE_PARITY_EN
    checkVal({tag, "_out_parity"}, 32'(w_out_parity), 32'd0);
`endif
  endtask

  logic [NIN*WIDTH-1:0] mix_ops;
  logic [NIN*WIDTH-1:0] one_hot;
  logic [WIDTH-1:0]     exp_tab [8];

  initial begin
    exp_tab = '{8'hFF, 8'h00, 8'h3C, 8'h00, 8'hFF, 8'hC3, 8'hFF, 8'h00};
    mix_ops = {8'h3C, 8'hF0, 8'h0F, 8'hFF};
    one_hot = {8'h08, 8'h04, 8'h02, 8'h01};

    w_rst = 1'b1; w_in_valid = 1'b0; w_in_op = 3'd0; w_in_data = '0; w_out_ready = 1'b0;
    #1;
    checkResetValues("reset");
    repeat (2) @(negedge w_clk);
    w_rst = 1'b0;

    // OR of one-hot operands, then consumer pops it.
    applyStimulus(1'b1, 3'd0, one_hot, 1'b1);
    checkVal("or_data", 32'(w_out_data), 32'h0F);
    checkVal("or_any", 32'(w_out_any), 32'd1);
    applyStimulus(1'b0, 3'd0, '0, 1'b1);
    checkVal("or_count", 32'(w_out_count), 32'd1);

    // Every op on the mixed operand set, streamed with the consumer ready.
    for (int op = 0; op < 8; op++) begin
      applyStimulus(1'b1, 3'(op), mix_ops, 1'b1);
      checkVal($sformatf("op%0d_data", op), 32'(w_out_data), 32'(exp_tab[op]));
    end
    applyStimulus(1'b1, 3'd3, one_hot, 1'b1);
    checkVal("nor_data", 32'(w_out_data), 32'hF0);
    applyStimulus(1'b0, 3'd0, '0, 1'b1);

    // Backpressure: fill both entries, then drain in order.
    applyStimulus(1'b1, 3'd2, mix_ops, 1'b0);
    applyStimulus(1'b1, 3'd5, mix_ops, 1'b0);
    checkVal("full_in_ready", 32'(w_in_ready), 32'd0);
    applyStimulus(1'b1, 3'd0, one_hot, 1'b0);
    checkVal("held_data", 32'(w_out_data), 32'h3C);
    applyStimulus(1'b0, 3'd0, '0, 1'b1);
    checkVal("drain_in_ready", 32'(w_in_ready), 32'd1);
    checkVal("drain_second", 32'(w_out_data), 32'hC3);
    applyStimulus(1'b0, 3'd0, '0, 1'b1);

    // Occupancy held at one with simultaneous push and pop.
    applyStimulus(1'b1, 3'd6, 32'($urandom), 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 3'd6, 32'($urandom), 1'b1);
    checkVal("steady_depth", 32'(exp_q.size()), 32'd1);
    applyStimulus(1'b0, 3'd0, '0, 1'b1);

    // Parity-relevant result 07.
    applyStimulus(1'b1, 3'd0, {8'h00, 8'h04, 8'h02, 8'h01}, 1'b0);
    checkVal("res07_data", 32'(w_out_data), 32'h07);
`ifdef GATE_PIPE_PARITY_EN
    checkVal("res07_parity", 32'(w_out_parity), 32'd1);
`endif
    applyStimulus(1'b0, 3'd0, '0, 1'b1);

    // Random traffic against the queue model.
    for (int i = 0; i < 400; i++)
      applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 32'($urandom),
                    1'($urandom_range(0, 1)));

    // Asynchronous reset with two results buffered.
    applyStimulus(1'b1, 3'd0, one_hot, 1'b0);
    applyStimulus(1'b1, 3'd1, mix_ops, 1'b0);
    w_in_valid = 1'b0;
    w_out_ready = 1'b0;
    #2 w_rst = 1'b1;
    #1;
    checkResetValues("midreset");
    exp_q.delete();
    exp_count = 16'h0000;
    @(negedge w_clk);
    w_rst = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 3'd0, '0, 1'b1);

    // Counter wrap: 65536 pops from a streaming run.
    for (int i = 0; i < 65537; i++) applyStimulus(1'b1, 3'd6, 32'($urandom), 1'b1);
    checkVal("count_wrap", 32'(w_out_count), 32'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
